mc_port_arb: RTL and testbench
==============================

MC_PORT_ARB -- requirements
Module: mc_port_arb

Interface
REQ-001 Parameter NUM_CORE, default 4, number of phold core requesters; power of two, at least 2.
REQ-002 Parameter MC_RTNCTL_WIDTH, default 32, width of the memory-controller return-control field.
REQ-003 Parameter MAX_OUTSTANDING, default 8, per-core limit on issued requests awaiting a response.
REQ-004 Localparam ID_WID = log2(NUM_CORE), the core-id tag width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 core_rq_vld  in  NUM_CORE  per-core request valid.
REQ-008 core_rq_cmd / core_rq_scmd / core_rq_size / core_rq_flush  in  3*NUM_CORE / 4*NUM_CORE / 2*NUM_CORE / NUM_CORE  per-core request fields, core g in slice g.
REQ-009 core_rq_vadr / core_rq_data / core_rq_rtnctl  in  48*NUM_CORE / 64*NUM_CORE / MC_RTNCTL_WIDTH*NUM_CORE  per-core address, write data and return control.
REQ-010 core_rq_ack  out  NUM_CORE  one-cycle pulse: core g's request is accepted this cycle.
REQ-011 mc_rq_vld, mc_rq_cmd[2:0], mc_rq_scmd[3:0], mc_rq_vadr[47:0], mc_rq_size[1:0], mc_rq_rtnctl[MC_RTNCTL_WIDTH-1:0], mc_rq_data[63:0], mc_rq_flush  out  request to the memory controller.
REQ-012 mc_rq_stall  in  1  controller back-pressure.
REQ-013 mc_rs_vld, mc_rs_cmd[2:0], mc_rs_scmd[3:0], mc_rs_rtnctl, mc_rs_data[63:0]  in  controller response.
REQ-014 mc_rs_stall  out  1  response back-pressure.
REQ-015 core_rs_vld  out  NUM_CORE  per-core response valid; cmd/scmd/rtnctl/data are broadcast unchanged on the core_rs_* outputs.
REQ-016 core_rs_stall  in  NUM_CORE  per-core response back-pressure.
REQ-017 busy  out  1  high while any request is outstanding or the output register is full.
REQ-018 err_underflow  out  1  sticky: a response arrived for a core with a zero outstanding count.

Function
REQ-019 The output register SHALL have two states. EMPTY: mc_rq_vld=0. FULL: mc_rq_vld=1.
REQ-020 The block SHALL load the output register (EMPTY->FULL, or FULL->FULL when mc_rq_stall=0) from one granted core per cycle; FULL->EMPTY when mc_rq_stall=0 and there is no grant.
REQ-021 While FULL with mc_rq_stall=1, all mc_rq_* SHALL hold, no grant SHALL occur, and no ack SHALL be issued.
REQ-022 Eligibility: core_rq_vld[g]=1, flush=1 or outstanding[g] < MAX_OUTSTANDING.
REQ-023 Round-robin: search starts at last granted id+1 (wrapping NUM_CORE-1->0); the pointer advances only on a grant.
REQ-024 core_rq_ack[g] SHALL pulse in the grant cycle; mc_rq_* SHALL appear the next cycle (one-cycle latency).
REQ-025 mc_rq_rtnctl = {core rtnctl[MC_RTNCTL_WIDTH-1:ID_WID], granted id}.
REQ-026 A response SHALL be routed to core id = mc_rs_rtnctl[ID_WID-1:0]; core_rs_vld[id] = mc_rs_vld, others 0.
REQ-027 mc_rs_stall = core_rs_stall[mc_rs_rtnctl[ID_WID-1:0]] when mc_rs_vld=1, else 0.
REQ-028 outstanding[g] SHALL increment on a non-flush grant to g and decrement on an accepted response (mc_rs_vld & ~mc_rs_stall) for g; simultaneous increment and decrement leaves it unchanged.
REQ-029 A decrement at zero SHALL leave the count at 0 and set err_underflow.
REQ-030 Flush requests SHALL NOT be counted; they are issued like any other request.

Reset
REQ-031 Reset SHALL force, asynchronously: output register EMPTY, mc_rq_* = 0, pointer = NUM_CORE-1, all counters 0, err_underflow = 0, core_rq_ack = 0.

Structure
REQ-032 NUM_CORE, ID_WID and the memory-controller command encodings SHALL live in a shared phold package.
REQ-033 The round-robin selector SHALL be the existing rrarb sub-module, with eligibility masking applied to its req input and its stall driven by the FULL-and-stalled condition.

Verification
REQ-034 All four cores request continuously, no stall -> acks in order 0,1,2,3,0, one per cycle; mc_rq_vld high from cycle 2.
REQ-035 mc_rq_stall high for 5 cycles while FULL -> mc_rq_* held, zero acks, pointer unchanged; issue resumes the cycle stall drops.
REQ-036 Core 1 issues 8 reads with no responses -> core 1 is masked while cores 0, 2 and 3 keep receiving grants; one response with rtnctl[1:0]=1 -> core 1 is granted again.
REQ-037 Response with rtnctl[1:0]=2 and core_rs_stall[2]=1 -> core_rs_vld=4'b0100 and mc_rs_stall=1; outstanding[2] unchanged until the stall is released.
REQ-038 Response for core 3 while outstanding[3]=0 -> err_underflow=1 and stays high until reset.
REQ-039 Reset asserted mid-transfer with the register FULL -> mc_rq_vld=0 immediately; busy=0; after release, core 0 is granted first.

Source files
------------

// File: rtl/mc_port_arb_pkg.sv
// Shared phold definitions: core count, core-id tag width and the
// memory-controller command encodings used by the port arbiter.
package mc_port_arb_pkg;

  localparam int PHOLD_NUM_CORE = 4;
  localparam int PHOLD_ID_WID   = $clog2(PHOLD_NUM_CORE);

  typedef enum logic [2:0] {
    MC_CMD_IDLE   = 3'd0,
    MC_CMD_RD     = 3'd1,
    MC_CMD_WR     = 3'd2,
    MC_CMD_RDWR   = 3'd3,
    MC_CMD_ATOMIC = 3'd4,
    MC_CMD_FENCE  = 3'd5,
    MC_CMD_RS_RD  = 3'd6,
    MC_CMD_RS_WR  = 3'd7
  } mc_cmd_e;

endpackage

// File: rtl/mc_port_arb_rrarb.sv
// Round-robin selector: one-hot grant among req, search starting one past the
// last granted id. The pointer only moves on a grant; stall suppresses grants.
module rrarb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 stall,
  output logic [N-1:0]         gnt,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last;
  logic [IW-1:0] idx;

  // Search last+1 .. last+N (wrapping); N is a power of two so IW-bit add wraps.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (!stall && !reset) begin
      for (int k = 1; k <= N; k++) begin
        idx = last + IW'(k);
        if (!gnt_vld && req[idx]) begin
          gnt_vld  = 1'b1;
          gnt_id   = idx;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  // Remember the last granted id; reset points at N-1 so core 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= IW'(N - 1);
    end else if (gnt_vld) begin
      last <= gnt_id;
    end
  end

endmodule

// File: rtl/mc_port_arb.sv
// Memory-controller port arbiter: round-robin multiplexes NUM_CORE core request
// ports into one registered controller request, tags rtnctl with the core id,
// routes responses back by that tag and tracks per-core outstanding requests.
module mc_port_arb
  import mc_port_arb_pkg::*;
#(
  parameter int NUM_CORE        = PHOLD_NUM_CORE,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CORE-1:0]                 core_rq_vld,
  input  logic [3*NUM_CORE-1:0]               core_rq_cmd,
  input  logic [4*NUM_CORE-1:0]               core_rq_scmd,
  input  logic [2*NUM_CORE-1:0]               core_rq_size,
  input  logic [NUM_CORE-1:0]                 core_rq_flush,
  input  logic [48*NUM_CORE-1:0]              core_rq_vadr,
  input  logic [64*NUM_CORE-1:0]              core_rq_data,
  input  logic [MC_RTNCTL_WIDTH*NUM_CORE-1:0] core_rq_rtnctl,
  output logic [NUM_CORE-1:0]                 core_rq_ack,
  output logic                                mc_rq_vld,
  output logic [2:0]                          mc_rq_cmd,
  output logic [3:0]                          mc_rq_scmd,
  output logic [47:0]                         mc_rq_vadr,
  output logic [1:0]                          mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0]          mc_rq_rtnctl,
  output logic [63:0]                         mc_rq_data,
  output logic                                mc_rq_flush,
  input  logic                                mc_rq_stall,
  input  logic                                mc_rs_vld,
  input  logic [2:0]                          mc_rs_cmd,
  input  logic [3:0]                          mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0]          mc_rs_rtnctl,
  input  logic [63:0]                         mc_rs_data,
  output logic                                mc_rs_stall,
  output logic [NUM_CORE-1:0]                 core_rs_vld,
  output logic [2:0]                          core_rs_cmd,
  output logic [3:0]                          core_rs_scmd,
  output logic [MC_RTNCTL_WIDTH-1:0]          core_rs_rtnctl,
  output logic [63:0]                         core_rs_data,
  input  logic [NUM_CORE-1:0]                 core_rs_stall,
  output logic                                busy,
  output logic                                err_underflow
);

  localparam int ID_WID = $clog2(NUM_CORE);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int HI_W   = MC_RTNCTL_WIDTH - ID_WID;

  // Per-core views of the flattened request buses.
  logic [2:0]      rq_cmd    [NUM_CORE];
  logic [3:0]      rq_scmd   [NUM_CORE];
  logic [1:0]      rq_size   [NUM_CORE];
  logic [47:0]     rq_vadr   [NUM_CORE];
  logic [63:0]     rq_data   [NUM_CORE];
  logic [HI_W-1:0] rq_rtn_hi [NUM_CORE];

  for (genvar g = 0; g < NUM_CORE; g++) begin : g_unpack
    assign rq_cmd[g]    = core_rq_cmd[g*3 +: 3];
    assign rq_scmd[g]   = core_rq_scmd[g*4 +: 4];
    assign rq_size[g]   = core_rq_size[g*2 +: 2];
    assign rq_vadr[g]   = core_rq_vadr[g*48 +: 48];
    assign rq_data[g]   = core_rq_data[g*64 +: 64];
    assign rq_rtn_hi[g] = core_rq_rtnctl[g*MC_RTNCTL_WIDTH + ID_WID +: HI_W];
  end

  // The low ID_WID rtnctl bits of each core are overwritten by the core id.
  logic rtnctl_id_bits_unused;
  assign rtnctl_id_bits_unused = ^core_rq_rtnctl;

  logic [CNT_W-1:0]  outstanding [NUM_CORE];
  logic [NUM_CORE-1:0] elig;
  logic [NUM_CORE-1:0] gnt;
  logic                gnt_vld;
  logic [ID_WID-1:0]   gnt_id;
  logic                hold;

  assign hold = mc_rq_vld & mc_rq_stall;

  // A core may compete if it requests and is a flush or below its outstanding limit.
  always_comb begin
    elig = '0;
    for (int g = 0; g < NUM_CORE; g++) begin
      elig[g] = core_rq_vld[g] &
                (core_rq_flush[g] | (outstanding[g] < CNT_W'(MAX_OUTSTANDING)));
    end
  end

  rrarb #(.N(NUM_CORE)) u_rrarb (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .stall   (hold),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign core_rq_ack = gnt;

  // Output register: load the granted core, drain when idle, freeze while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mc_rq_vld    <= 1'b0;
      mc_rq_cmd    <= '0;
      mc_rq_scmd   <= '0;
      mc_rq_vadr   <= '0;
      mc_rq_size   <= '0;
      mc_rq_rtnctl <= '0;
      mc_rq_data   <= '0;
      mc_rq_flush  <= 1'b0;
    end else if (!hold) begin
      if (gnt_vld) begin
        mc_rq_vld    <= 1'b1;
        mc_rq_cmd    <= rq_cmd[gnt_id];
        mc_rq_scmd   <= rq_scmd[gnt_id];
        mc_rq_vadr   <= rq_vadr[gnt_id];
        mc_rq_size   <= rq_size[gnt_id];
        mc_rq_rtnctl <= {rq_rtn_hi[gnt_id], gnt_id};
        mc_rq_data   <= rq_data[gnt_id];
        mc_rq_flush  <= core_rq_flush[gnt_id];
      end else begin
        mc_rq_vld <= 1'b0;
      end
    end
  end

  // Response routing by the core-id tag carried in the low rtnctl bits.
  logic [ID_WID-1:0] rs_id;
  logic              rs_acc;

  assign rs_id          = mc_rs_rtnctl[ID_WID-1:0];
  assign core_rs_vld    = mc_rs_vld ? (NUM_CORE'(1) << rs_id) : '0;
  assign mc_rs_stall    = mc_rs_vld & core_rs_stall[rs_id];
  assign rs_acc         = mc_rs_vld & ~mc_rs_stall;
  assign core_rs_cmd    = mc_rs_cmd;
  assign core_rs_scmd   = mc_rs_scmd;
  assign core_rs_rtnctl = mc_rs_rtnctl;
  assign core_rs_data   = mc_rs_data;

  logic [NUM_CORE-1:0] cnt_inc;
  logic [NUM_CORE-1:0] cnt_dec;

  // Non-flush grants add to a core's count; accepted responses subtract.
  always_comb begin
    cnt_inc = gnt & ~core_rq_flush;
    cnt_dec = '0;
    for (int g = 0; g < NUM_CORE; g++) begin
      cnt_dec[g] = rs_acc & (rs_id == ID_WID'(g));
    end
  end

  // Outstanding counters with sticky underflow detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < NUM_CORE; g++) begin
        outstanding[g] <= '0;
      end
      err_underflow <= 1'b0;
    end else begin
      for (int g = 0; g < NUM_CORE; g++) begin
        if (cnt_inc[g] && !cnt_dec[g]) begin
          outstanding[g] <= outstanding[g] + CNT_W'(1);
        end else if (cnt_dec[g] && !cnt_inc[g]) begin
          if (outstanding[g] == '0) begin
            err_underflow <= 1'b1;
          end else begin
            outstanding[g] <= outstanding[g] - CNT_W'(1);
          end
        end
      end
    end
  end

  // Busy while the output register holds a request or any core has one in flight.
  always_comb begin
    busy = mc_rq_vld;
    for (int g = 0; g < NUM_CORE; g++) begin
      if (outstanding[g] != '0) begin
        busy = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_port_arb.sv
// Bench for mc_port_arb: a cycle model built from the arbitration, routing
// and counting rules checks every output each cycle, and directed scenarios
// pin the model with hand-computed literals.
module tb_mc_port_arb;

  localparam int N    = 4;
  localparam int RW   = 32;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]      core_rq_vld;
  logic [3*N-1:0]    core_rq_cmd;
  logic [4*N-1:0]    core_rq_scmd;
  logic [2*N-1:0]    core_rq_size;
  logic [N-1:0]      core_rq_flush;
  logic [48*N-1:0]   core_rq_vadr;
  logic [64*N-1:0]   core_rq_data;
  logic [RW*N-1:0]   core_rq_rtnctl;
  logic [N-1:0]      core_rq_ack;
  logic              mc_rq_vld;
  logic [2:0]        mc_rq_cmd;
  logic [3:0]        mc_rq_scmd;
  logic [47:0]       mc_rq_vadr;
  logic [1:0]        mc_rq_size;
  logic [RW-1:0]     mc_rq_rtnctl;
  logic [63:0]       mc_rq_data;
  logic              mc_rq_flush;
  logic              mc_rq_stall;
  logic              mc_rs_vld;
  logic [2:0]        mc_rs_cmd;
  logic [3:0]        mc_rs_scmd;
  logic [RW-1:0]     mc_rs_rtnctl;
  logic [63:0]       mc_rs_data;
  logic              mc_rs_stall;
  logic [N-1:0]      core_rs_vld;
  logic [2:0]        core_rs_cmd;
  logic [3:0]        core_rs_scmd;
  logic [RW-1:0]     core_rs_rtnctl;
  logic [63:0]       core_rs_data;
  logic [N-1:0]      core_rs_stall;
  logic              busy;
  logic              err_underflow;

  mc_port_arb #(.NUM_CORE(N), .MC_RTNCTL_WIDTH(RW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset),
    .core_rq_vld(core_rq_vld), .core_rq_cmd(core_rq_cmd), .core_rq_scmd(core_rq_scmd),
    .core_rq_size(core_rq_size), .core_rq_flush(core_rq_flush), .core_rq_vadr(core_rq_vadr),
    .core_rq_data(core_rq_data), .core_rq_rtnctl(core_rq_rtnctl), .core_rq_ack(core_rq_ack),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall),
    .core_rs_vld(core_rs_vld), .core_rs_cmd(core_rs_cmd), .core_rs_scmd(core_rs_scmd),
    .core_rs_rtnctl(core_rs_rtnctl), .core_rs_data(core_rs_data),
    .core_rs_stall(core_rs_stall), .busy(busy), .err_underflow(err_underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh2id(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  int          m_ptr;
  int          m_out [N];
  bit          m_vld;
  bit          m_err;
  logic [2:0]  m_cmd;
  logic [3:0]  m_scmd;
  logic [47:0] m_vadr;
  logic [1:0]  m_size;
  logic [RW-1:0] m_rtnctl;
  logic [63:0] m_data;
  logic        m_flush;

  always @(negedge clk) begin
    int g, rid, d;
    bit hold, rs_st, acc, anyo;
    logic [N-1:0] e_ack, e_rsv;
    if (reset) begin
      m_vld = 0; m_err = 0; m_ptr = N - 1;
      for (int c = 0; c < N; c++) m_out[c] = 0;
      chk("rst_mc_rq_vld", mc_rq_vld, 0);
      chk("rst_mc_rq_vadr", mc_rq_vadr, 0);
      chk("rst_mc_rq_rtnctl", mc_rq_rtnctl, 0);
      chk("rst_ack", core_rq_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_underflow, 0);
    end else begin
      hold = m_vld && mc_rq_stall;
      g = -1;
      if (!hold) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (g < 0 && core_rq_vld[c] && (core_rq_flush[c] || m_out[c] < MAXO)) g = c;
        end
      end
      e_ack = (g >= 0) ? (N'(1) << g) : '0;
      rid   = int'(mc_rs_rtnctl % RW'(N));
      e_rsv = mc_rs_vld ? (N'(1) << rid) : '0;
      rs_st = mc_rs_vld && core_rs_stall[rid];
      acc   = mc_rs_vld && !rs_st;
      anyo  = 0;
      for (int c = 0; c < N; c++) if (m_out[c] > 0) anyo = 1;

      chk("ack", core_rq_ack, e_ack);
      chk("mc_rq_vld", mc_rq_vld, m_vld);
      chk("core_rs_vld", core_rs_vld, e_rsv);
      chk("mc_rs_stall", mc_rs_stall, rs_st);
      chk("core_rs_rtnctl", core_rs_rtnctl, mc_rs_rtnctl);
      chk("busy", busy, m_vld || anyo);
      chk("err_underflow", err_underflow, m_err);
      if (m_vld) begin
        chk("mc_rq_cmd", mc_rq_cmd, m_cmd);
        chk("mc_rq_scmd", mc_rq_scmd, m_scmd);
        chk("mc_rq_vadr", mc_rq_vadr, m_vadr);
        chk("mc_rq_size", mc_rq_size, m_size);
        chk("mc_rq_rtnctl", mc_rq_rtnctl, m_rtnctl);
        chk("mc_rq_data", mc_rq_data, m_data);
        chk("mc_rq_flush", mc_rq_flush, m_flush);
      end

      if (!hold) begin
        if (g >= 0) begin
          m_vld    = 1;
          m_cmd    = core_rq_cmd[g*3 +: 3];
          m_scmd   = core_rq_scmd[g*4 +: 4];
          m_vadr   = core_rq_vadr[g*48 +: 48];
          m_size   = core_rq_size[g*2 +: 2];
          m_data   = core_rq_data[g*64 +: 64];
          m_flush  = core_rq_flush[g];
          m_rtnctl = (core_rq_rtnctl[g*RW +: RW] / RW'(N)) * RW'(N) + RW'(g);
          m_ptr    = g;
        end else begin
          m_vld = 0;
        end
      end
      for (int c = 0; c < N; c++) begin
        d = 0;
        if (g == c && !core_rq_flush[c]) d++;
        if (acc && rid == c) d--;
        if (d < 0 && m_out[c] == 0) m_err = 1;
        else m_out[c] += d;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; core_rq_vld = '0; core_rq_flush = '0; mc_rq_stall = 0;
    mc_rs_vld = 0; core_rs_stall = '0; mc_rs_rtnctl = '0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int ack_q[$];
  int vld_q[$];
  int exp_ack[5] = '{0, 1, 2, 3, 0};
  int exp_vld[5] = '{0, 1, 1, 1, 1};
  int cnt0, cnt1, nacks;
  bit seen;

  initial begin
    core_rq_vld = '0; core_rq_flush = '0; mc_rq_stall = 0;
    mc_rs_vld = 0; mc_rs_cmd = 3'd2; mc_rs_scmd = 4'd5; mc_rs_rtnctl = '0;
    mc_rs_data = 64'h5555_AAAA_1234_8765; core_rs_stall = '0;
    for (int g = 0; g < N; g++) begin
      core_rq_cmd[g*3 +: 3]      = 3'(g + 1);
      core_rq_scmd[g*4 +: 4]     = 4'(g + 8);
      core_rq_size[g*2 +: 2]     = 2'(g);
      core_rq_vadr[g*48 +: 48]   = 48'h0000_A000_0000 + 48'(g * 'h100);
      core_rq_data[g*64 +: 64]   = 64'hC0DE_0000_0000_0000 + 64'(g);
      core_rq_rtnctl[g*RW +: RW] = 32'h1234_5673 + 32'(g * 16);
    end
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // continuous requests from every core
    step();
    core_rq_vld = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ack_q.push_back(oh2id(core_rq_ack));
      vld_q.push_back(int'(mc_rq_vld));
      if (i == 1) chk("first_rtnctl", mc_rq_rtnctl, 32'h1234_5670);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk("ack_order", ack_q[i], exp_ack[i]);
      chk("vld_from_cycle2", vld_q[i], exp_vld[i]);
    end

    // stall while FULL
    do_reset();
    core_rq_vld = '1;
    repeat (3) begin @(negedge clk); step(); end
    mc_rq_stall = 1;
    nacks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (core_rq_ack != '0) nacks++;
      chk("stall_vadr_held", mc_rq_vadr, 48'h0000_A000_0200);
      step();
    end
    chk("stall_no_acks", nacks, 0);
    mc_rq_stall = 0;
    @(negedge clk);
    chk("resume_ack_core3", core_rq_ack, 4'b1000);
    step();

    // core 1 hits its outstanding limit; others issue flushes
    do_reset();
    core_rq_flush = 4'b1101;
    core_rq_vld = '1;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 52; i++) begin
      @(negedge clk);
      if (core_rq_ack[1]) cnt1++;
      if (i >= 40 && core_rq_ack[0]) cnt0++;
      if (i == 40) chk("c1_total_grants", cnt1, 8);
      step();
    end
    chk("c1_masked_total", cnt1, 8);
    chk("c0_grants_while_c1_masked", cnt0, 4);
    mc_rs_vld = 1; mc_rs_rtnctl = 32'h0000_0001;
    step();
    mc_rs_vld = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (core_rq_ack[1]) seen = 1;
      step();
    end
    chk("c1_regranted", seen, 1);

    // stalled response for core 2
    do_reset();
    core_rq_vld = 4'b0100;
    nacks = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (core_rq_ack[2]) nacks++;
      step();
    end
    core_rq_vld = '0;
    chk("c2_two_grants", nacks, 2);
    step(); step();
    mc_rs_vld = 1; mc_rs_rtnctl = 32'hABCD_0002; core_rs_stall = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rs_route_c2", core_rs_vld, 4'b0100);
      chk("rs_stall_c2", mc_rs_stall, 1);
      step();
    end
    core_rs_stall = '0;
    step(); step();
    mc_rs_vld = 0;
    @(negedge clk);
    chk("no_underflow_after_two", err_underflow, 0);
    chk("idle_after_drain", busy, 0);

    // underflow on core 3
    step();
    mc_rs_vld = 1; mc_rs_rtnctl = 32'h0000_0003;
    step();
    mc_rs_vld = 0;
    @(negedge clk);
    chk("underflow_set", err_underflow, 1);
    core_rq_vld = 4'b0011;
    repeat (5) step();
    core_rq_vld = '0;
    @(negedge clk);
    chk("underflow_sticky", err_underflow, 1);

    // reset mid-transfer with the register full
    do_reset();
    core_rq_vld = '1;
    repeat (3) step();
    reset = 1;
    #1;
    chk("async_rst_vld", mc_rq_vld, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ack", core_rq_ack, 0);
    step();
    reset = 0;
    @(negedge clk);
    chk("post_rst_core0_first", core_rq_ack, 4'b0001);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
